// File: rtl/fp16_unpack.sv
// fp16_unpack: decodes IEEE-754 half-precision words into sign / shift / mantissa for the
// downstream barrel shifter. Optional event counters are built when FP16_UNPACK_STATS_EN is defined.
module fp16_unpack #(
    parameter int FRAC_BITS = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] fp16_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        ready_i,
    output logic        sign_o,
    output logic [4:0]  shft_amt_o,
    output logic [11:0] mant_o,
    output logic        valid_o,
    output logic        valid_d_o,
    output logic        sign_d_o,
    output logic [2:0]  flags_d_o,
    input  logic        clr_stats_i,
    output logic [15:0] ovf_cnt_o,
    output logic [15:0] uflow_cnt_o,
    output logic [15:0] nan_cnt_o
);

    // Shift bias folds the fp16 exponent bias (15) and the 10 fraction bits into one constant.
    localparam logic signed [7:0] SH_BIAS    = 8'(FRAC_BITS - 25);
    localparam logic [2:0]        FLAG_NAN   = 3'b100;
    localparam logic [2:0]        FLAG_OVF   = 3'b010;
    localparam logic [2:0]        FLAG_UFLOW = 3'b001;

    logic [15:0]       buf_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic [1:0]        count_nxt_s;
    logic              push_s;
    logic              pop_s;
    logic [2:0]        flags_r;

    logic [15:0]       head_s;
    logic              s_s;
    logic [4:0]        e_s;
    logic [9:0]        f_s;
    logic signed [7:0] sh_s;
    logic [11:0]       m_s;
    logic              dec_sign_s;
    logic [4:0]        dec_shft_s;
    logic [11:0]       dec_mant_s;
    logic [2:0]        dec_flags_s;

    assign push_s = valid_i && ready_o;
    assign pop_s  = (count_r != 2'd0) && ready_i;

    // Buffer occupancy for the next cycle.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + 2'd1;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - 2'd1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Two-entry skid buffer storage, pointers, count and registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_r[0] <= 16'h0000;
            buf_r[1] <= 16'h0000;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            ready_o  <= 1'b1;
        end else begin
            if (push_s) begin
                buf_r[wr_ptr_r] <= fp16_i;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_nxt_s;
            ready_o <= (count_nxt_s < 2'd2);
        end
    end

    assign head_s = buf_r[rd_ptr_r];
    assign s_s    = head_s[15];
    assign e_s    = head_s[14:10];
    assign f_s    = head_s[9:0];
    assign sh_s   = $signed({3'b000, e_s}) + SH_BIAS;
    assign m_s    = {2'b01, f_s};

    // Decode of the head entry; denormals flush to +0, every exception forces a zero mantissa.
    always_comb begin
        dec_sign_s  = 1'b0;
        dec_shft_s  = 5'd0;
        dec_mant_s  = 12'h000;
        dec_flags_s = 3'b000;
        if (e_s == 5'd0) begin
            dec_sign_s = 1'b0;
        end else if (e_s == 5'd31) begin
            dec_sign_s  = s_s;
            dec_flags_s = (f_s != 10'd0) ? FLAG_NAN : FLAG_OVF;
        end else if (sh_s > 8'sd31) begin
            dec_sign_s  = s_s;
            dec_flags_s = FLAG_OVF;
        end else if (sh_s < 8'sd0) begin
            dec_sign_s  = s_s;
            dec_flags_s = FLAG_UFLOW;
        end else begin
            dec_sign_s = s_s;
            dec_shft_s = sh_s[4:0];
            dec_mant_s = s_s ? (~m_s + 12'd1) : m_s;
        end
    end

    // Issue registers: loaded only when an entry leaves the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o    <= 1'b0;
            sign_o     <= 1'b0;
            shft_amt_o <= 5'd0;
            mant_o     <= 12'h000;
            flags_r    <= 3'b000;
        end else begin
            valid_o <= pop_s;
            if (pop_s) begin
                sign_o     <= dec_sign_s;
                shft_amt_o <= dec_shft_s;
                mant_o     <= dec_mant_s;
                flags_r    <= dec_flags_s;
            end
        end
    end

    // Delay line matching the shifter's single register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_d_o <= 1'b0;
            sign_d_o  <= 1'b0;
            flags_d_o <= 3'b000;
        end else begin
            valid_d_o <= valid_o;
            sign_d_o  <= sign_o;
            flags_d_o <= flags_r;
        end
    end

`ifdef FP16_UNPACK_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_o   <= 16'h0000;
            uflow_cnt_o <= 16'h0000;
            nan_cnt_o   <= 16'h0000;
        end else if (clr_stats_i) begin
            ovf_cnt_o   <= 16'h0000;
            uflow_cnt_o <= 16'h0000;
            nan_cnt_o   <= 16'h0000;
        end else if (pop_s) begin
            if (dec_flags_s[1]) begin
                ovf_cnt_o <= sat_inc(ovf_cnt_o);
            end
            if (dec_flags_s[0]) begin
                uflow_cnt_o <= sat_inc(uflow_cnt_o);
            end
            if (dec_flags_s[2]) begin
                nan_cnt_o <= sat_inc(nan_cnt_o);
            end
        end
    end
`else
    logic unused_clr_stats_s;
    assign unused_clr_stats_s = clr_stats_i;
    assign ovf_cnt_o          = 16'h0000;
    assign uflow_cnt_o        = 16'h0000;
    assign nan_cnt_o          = 16'h0000;
`endif

endmodule

// File: tb/tb_fp16_unpack.sv
// Scoreboard bench for fp16_unpack: three instances (FRAC_BITS 24/16/30) share one stimulus
// stream; expectations are queued at push time and checked by a negedge monitor.
module tb_fp16_unpack;

    typedef struct packed {
        logic [15:0]       word;
        logic              sign;
        logic [2:0][2:0]   flags;
        logic [2:0][4:0]   shft;
        logic [2:0][11:0]  mant;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [15:0]       fp16 = 16'h0000;
    logic              valid = 1'b0;
    logic              rdy_in = 1'b1;
    logic              clr = 1'b0;
    logic [2:0]        rdy, v_o, v_d, sg_o, sg_d;
    logic [2:0][4:0]   sh;
    logic [2:0][11:0]  mt;
    logic [2:0][2:0]   fl;
    logic [2:0][15:0]  oc, uc, nc;

    vec_t vecs[$];
    vec_t q_o[$];
    vec_t q_d[$];
    vec_t mon_o, mon_d;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_ovf[3];
    int   exp_uf[3];
    int   exp_nan[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fp16_unpack #(.FRAC_BITS((g == 0) ? 24 : ((g == 1) ? 16 : 30))) u_dut (
            .clk(clk), .reset(reset), .fp16_i(fp16), .valid_i(valid), .ready_o(rdy[g]),
            .ready_i(rdy_in), .sign_o(sg_o[g]), .shft_amt_o(sh[g]), .mant_o(mt[g]),
            .valid_o(v_o[g]), .valid_d_o(v_d[g]), .sign_d_o(sg_d[g]), .flags_d_o(fl[g]),
            .clr_stats_i(clr), .ovf_cnt_o(oc[g]), .uflow_cnt_o(uc[g]), .nan_cnt_o(nc[g])
        );
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [dut%0d]: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Index 0: FRAC_BITS=24, 1: FRAC_BITS=16, 2: FRAC_BITS=30.
    task automatic add_vec(input logic [15:0] w, input logic sg,
                           input logic [2:0] f0, input logic [4:0] s0, input logic [11:0] m0,
                           input logic [2:0] f1, input logic [4:0] s1, input logic [11:0] m1,
                           input logic [2:0] f2, input logic [4:0] s2, input logic [11:0] m2);
        vec_t v;
        v.word = w;
        v.sign = sg;
        v.flags[0] = f0; v.shft[0] = s0; v.mant[0] = m0;
        v.flags[1] = f1; v.shft[1] = s1; v.mant[1] = m1;
        v.flags[2] = f2; v.shft[2] = s2; v.mant[2] = m2;
        vecs.push_back(v);
    endtask

    task automatic sb_push(input vec_t v);
        q_o.push_back(v);
        q_d.push_back(v);
        for (int k = 0; k < 3; k++) begin
            exp_nan[k] += int'(v.flags[k][2]);
            exp_ovf[k] += int'(v.flags[k][1]);
            exp_uf[k]  += int'(v.flags[k][0]);
        end
    endtask

    task automatic push_word(input vec_t v);
        logic acc;
        bit   done;
        done  = 1'b0;
        fp16  = v.word;
        valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            acc = rdy[0];
            @(posedge clk);
            #1;
            if (acc) begin
                sb_push(v);
                done = 1'b1;
            end
        end
        if (!done) chk("push_timeout", 0, 32'd0, 32'd1);
        valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q_d.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk("drain_timeout", 0, 32'(q_d.size()), 32'd0);
    endtask

    task automatic check_counters(input string tag);
        for (int k = 0; k < 3; k++) begin
`ifdef FP16_UNPACK_STATS_EN
            chk({tag, "_ovf_cnt"}, k, 32'(oc[k]), 32'(exp_ovf[k]));
            chk({tag, "_uflow_cnt"}, k, 32'(uc[k]), 32'(exp_uf[k]));
            chk({tag, "_nan_cnt"}, k, 32'(nc[k]), 32'(exp_nan[k]));
`else
            chk({tag, "_ovf_cnt"}, k, 32'(oc[k]), 32'd0);
            chk({tag, "_uflow_cnt"}, k, 32'(uc[k]), 32'd0);
            chk({tag, "_nan_cnt"}, k, 32'(nc[k]), 32'd0);
`endif
        end
    endtask

    // Monitor: pops expectations whenever an issue strobe or delayed strobe is presented.
    always @(negedge clk) begin
        if (!reset) begin
            if (v_o != 3'b000) begin
                if (q_o.size() == 0) begin
                    chk("valid_o_unexpected", 0, 32'(v_o), 32'd0);
                end else begin
                    mon_o = q_o.pop_front();
                    for (int k = 0; k < 3; k++) begin
                        chk("valid_o", k, 32'(v_o[k]), 32'd1);
                        chk("sign_o", k, 32'(sg_o[k]), 32'(mon_o.sign));
                        chk("shft_amt_o", k, 32'(sh[k]), 32'(mon_o.shft[k]));
                        chk("mant_o", k, 32'(mt[k]), 32'(mon_o.mant[k]));
                    end
                end
            end
            if (v_d != 3'b000) begin
                if (q_d.size() == 0) begin
                    chk("valid_d_o_unexpected", 0, 32'(v_d), 32'd0);
                end else begin
                    mon_d = q_d.pop_front();
                    for (int k = 0; k < 3; k++) begin
                        chk("valid_d_o", k, 32'(v_d[k]), 32'd1);
                        chk("sign_d_o", k, 32'(sg_d[k]), 32'(mon_d.sign));
                        chk("flags_d_o", k, 32'(fl[k]), 32'(mon_d.flags[k]));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            exp_ovf[k] = 0; exp_uf[k] = 0; exp_nan[k] = 0;
        end
        //        word      s  |-- FB=24 ---------| |-- FB=16 ---------| |-- FB=30 ---------|
        add_vec(16'h3C00, 1'b0, 3'b000, 5'd14, 12'h400, 3'b000, 5'd6,  12'h400, 3'b000, 5'd20, 12'h400);
        add_vec(16'hC000, 1'b1, 3'b000, 5'd15, 12'hC00, 3'b000, 5'd7,  12'hC00, 3'b000, 5'd21, 12'hC00);
        add_vec(16'h7C00, 1'b0, 3'b010, 5'd0,  12'h000, 3'b010, 5'd0,  12'h000, 3'b010, 5'd0,  12'h000);
        add_vec(16'hFC01, 1'b1, 3'b100, 5'd0,  12'h000, 3'b100, 5'd0,  12'h000, 3'b100, 5'd0,  12'h000);
        add_vec(16'h0001, 1'b0, 3'b000, 5'd0,  12'h000, 3'b000, 5'd0,  12'h000, 3'b000, 5'd0,  12'h000);
        add_vec(16'h2000, 1'b0, 3'b000, 5'd7,  12'h400, 3'b001, 5'd0,  12'h000, 3'b000, 5'd13, 12'h400);
        add_vec(16'h7800, 1'b0, 3'b000, 5'd29, 12'h400, 3'b000, 5'd21, 12'h400, 3'b010, 5'd0,  12'h000);
        add_vec(16'hBE00, 1'b1, 3'b000, 5'd14, 12'hA00, 3'b000, 5'd6,  12'hA00, 3'b000, 5'd20, 12'hA00);
        add_vec(16'h0401, 1'b0, 3'b000, 5'd0,  12'h401, 3'b001, 5'd0,  12'h000, 3'b000, 5'd6,  12'h401);
        add_vec(16'h57FF, 1'b0, 3'b000, 5'd20, 12'h7FF, 3'b000, 5'd12, 12'h7FF, 3'b000, 5'd26, 12'h7FF);
        add_vec(16'hF800, 1'b1, 3'b000, 5'd29, 12'hC00, 3'b000, 5'd21, 12'hC00, 3'b010, 5'd0,  12'h000);
        add_vec(16'h6800, 1'b0, 3'b000, 5'd25, 12'h400, 3'b000, 5'd17, 12'h400, 3'b000, 5'd31, 12'h400);
        add_vec(16'h6C00, 1'b0, 3'b000, 5'd26, 12'h400, 3'b000, 5'd18, 12'h400, 3'b010, 5'd0,  12'h000);
        add_vec(16'h2400, 1'b0, 3'b000, 5'd8,  12'h400, 3'b000, 5'd0,  12'h400, 3'b000, 5'd14, 12'h400);
        add_vec(16'h8000, 1'b0, 3'b000, 5'd0,  12'h000, 3'b000, 5'd0,  12'h000, 3'b000, 5'd0,  12'h000);

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready_o", k, 32'(rdy[k]), 32'd1);
            chk("rst_valid_o", k, 32'(v_o[k]), 32'd0);
            chk("rst_valid_d_o", k, 32'(v_d[k]), 32'd0);
            chk("rst_sign_o", k, 32'(sg_o[k]), 32'd0);
            chk("rst_sign_d_o", k, 32'(sg_d[k]), 32'd0);
            chk("rst_shft_amt_o", k, 32'(sh[k]), 32'd0);
            chk("rst_mant_o", k, 32'(mt[k]), 32'd0);
            chk("rst_flags_d_o", k, 32'(fl[k]), 32'd0);
        end
        check_counters("rst");

        // Back-to-back stream with ready_i high.
        rdy_in = 1'b1;
        for (int i = 0; i < vecs.size(); i++) push_word(vecs[i]);
        drain();

        // Backpressure: ready_i low for 4 cycles while 5 words are offered.
        rdy_in = 1'b0;
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                rdy_in = 1'b1;
            end
            begin
                push_word(vecs[0]);
                push_word(vecs[1]);
                chk("ready_o_full", 0, 32'(rdy[0]), 32'd0);
                push_word(vecs[7]);
                push_word(vecs[9]);
                push_word(vecs[10]);
            end
        join
        drain();
        check_counters("stream");

        // Statistics clear.
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_ovf[k] = 0; exp_uf[k] = 0; exp_nan[k] = 0;
        end
        check_counters("clr");

        // Mid-stream reset: B and C buffered, A in the delay stage.
        rdy_in = 1'b0;
        fp16 = vecs[0].word;
        valid = 1'b1;
        @(posedge clk);
        #1;
        sb_push(vecs[0]);
        fp16 = vecs[1].word;
        @(posedge clk);
        #1;
        sb_push(vecs[1]);
        valid = 1'b0;
        rdy_in = 1'b1;
        @(posedge clk);
        #1;
        rdy_in = 1'b0;
        fp16 = vecs[7].word;
        valid = 1'b1;
        @(posedge clk);
        #1;
        sb_push(vecs[7]);
        valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        q_o.delete();
        q_d.delete();
        for (int k = 0; k < 3; k++) begin
            exp_ovf[k] = 0; exp_uf[k] = 0; exp_nan[k] = 0;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdy_in = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("post_rst_ready_o", k, 32'(rdy[k]), 32'd1);
        check_counters("post_rst");
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 3; k++) begin
                chk("post_rst_valid_o", k, 32'(v_o[k]), 32'd0);
                chk("post_rst_valid_d_o", k, 32'(v_d[k]), 32'd0);
            end
            @(posedge clk);
            #1;
        end

        chk("q_o_leftover", 0, 32'(q_o.size()), 32'd0);
        chk("q_d_leftover", 0, 32'(q_d.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
